ec_ladder_ctrl: RTL



---
 rtl/ec_ladder_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/ec_ladder_ctrl.sv
// Montgomery-ladder scalar multiplication controller: sequences
// SCAN/INIT/STEP/CONV over an external point-op unit (req/ack).
// Ports: clk, rst_n, start, abort, k, px, py -> busy, done, inf,
// x_out, y_out; op_req/op_sel/op_bit/operands <-> op_ack/results.
module ec_ladder_ctrl #(
  parameter int WIDTH = 256,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] px,
  input  logic [WIDTH-1:0] py,
  output logic             busy,
  output logic             done,
  output logic             inf,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic             op_req,
  output logic [1:0]       op_sel,
  output logic             op_bit,
  output logic [WIDTH-1:0] op_x1,
  output logic [WIDTH-1:0] op_z1,
  output logic [WIDTH-1:0] op_x2,
  output logic [WIDTH-1:0] op_z2,
  output logic [WIDTH-1:0] op_px,
  output logic [WIDTH-1:0] op_py,
  input  logic             op_ack,
  input  logic [WIDTH-1:0] op_ra_x,
  input  logic [WIDTH-1:0] op_ra_z,
  input  logic [WIDTH-1:0] op_rd_x,
  input  logic [WIDTH-1:0] op_rd_z
);

  typedef enum logic [2:0] {
    IDLE, SCAN, INIT, STEP, CONV, DONE
  } state_t;

  state_t           state, state_n;
  logic             req_n;
  logic [CNT_W-1:0] idx;
  logic [WIDTH-1:0] k_q, px_q, py_q;
  logic [WIDTH-1:0] r0x, r0z, r1x, r1z;
  logic             hs, cur_bit;

  logic ld_start, ld_r0, ld_zero;
  logic ld_init, ld_step, ld_conv;
  logic dec_idx;

  assign hs      = op_req & op_ack;
  assign cur_bit = k_q[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_req <= 1'b0;
    end else begin
      state  <= state_n;
      op_req <= req_n;
    end
  end

  // In op states req_n = ~hs: raise after the setup cycle,
  // hold until acked, then drop for one cycle.
  always_comb begin
    state_n  = state;
    req_n    = 1'b0;
    ld_start = 1'b0;
    ld_r0    = 1'b0;
    ld_zero  = 1'b0;
    ld_init  = 1'b0;
    ld_step  = 1'b0;
    ld_conv  = 1'b0;
    dec_idx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n  = SCAN;
          ld_start = 1'b1;
        end
      end
      SCAN: begin
        if (cur_bit) begin
          state_n = INIT;
          ld_r0   = 1'b1;
        end else if (idx != '0) begin
          dec_idx = 1'b1;
        end else begin
          state_n = DONE;
          ld_zero = 1'b1;
        end
      end
      INIT, STEP: begin
        req_n = ~hs;
        if (hs) begin
          ld_init = (state == INIT);
          ld_step = (state == STEP);
          if (idx == '0) begin
            state_n = CONV;
          end else begin
            state_n = STEP;
            dec_idx = 1'b1;
          end
        end
      end
      CONV: begin
        req_n = ~hs;
        if (hs) begin
          state_n = DONE;
          ld_conv = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n  = IDLE;
      req_n    = 1'b0;
      ld_start = 1'b0;
      ld_r0    = 1'b0;
      ld_zero  = 1'b0;
      ld_init  = 1'b0;
      ld_step  = 1'b0;
      ld_conv  = 1'b0;
      dec_idx  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      k_q   <= '0;
      px_q  <= '0;
      py_q  <= '0;
      r0x   <= '0;
      r0z   <= '0;
      r1x   <= '0;
      r1z   <= '0;
      inf   <= 1'b0;
      x_out <= '0;
      y_out <= '0;
    end else begin
      if (ld_start) begin
        k_q  <= k;
        px_q <= px;
        py_q <= py;
        idx  <= CNT_W'(WIDTH - 1);
        inf  <= 1'b0;
      end
      if (dec_idx) idx <= idx - CNT_W'(1);
      if (ld_r0) begin
        r0x <= px_q;
        r0z <= WIDTH'(1);
      end
      if (ld_zero) begin
        inf   <= 1'b1;
        x_out <= '0;
        y_out <= '0;
      end
      if (ld_init) begin
        r1x <= op_rd_x;
        r1z <= op_rd_z;
      end
      if (ld_step) begin
        if (cur_bit) begin
          r0x <= op_ra_x;
          r0z <= op_ra_z;
          r1x <= op_rd_x;
          r1z <= op_rd_z;
        end else begin
          r0x <= op_rd_x;
          r0z <= op_rd_z;
          r1x <= op_ra_x;
          r1z <= op_ra_z;
        end
      end
      if (ld_conv) begin
        x_out <= op_ra_x;
        y_out <= op_ra_z;
      end
    end
  end

  always_comb begin
    op_sel = 2'd0;
    unique case (state)
      INIT:    op_sel = 2'd1;
      STEP:    op_sel = 2'd2;
      CONV:    op_sel = 2'd3;
      default: op_sel = 2'd0;
    endcase
  end

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign op_bit = (state == STEP) & cur_bit;
  assign op_x1  = r0x;
  assign op_z1  = r0z;
  assign op_x2  = r1x;
  assign op_z2  = r1z;
  assign op_px  = px_q;
  assign op_py  = py_q;

endmodule
